// File: rtl/e_mdu_if.sv
// E-stage <-> multiply/divide unit bus: operation request, read select and
// the HI/LO/busy view returned to the pipeline.
interface e_mdu_if;
  logic [2:0]  mdop;
  logic [31:0] a;
  logic [31:0] b;
  logic        rd_sel;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic [31:0] rd_data;

  modport master (
    output mdop, a, b, rd_sel,
    input  start, busy, hi, lo, rd_data
  );

  modport slave (
    input  mdop, a, b, rd_sel,
    output start, busy, hi, lo, rd_data
  );
endinterface

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit: holds HI/LO, computes mult/div results
// on acceptance and commits them after a fixed busy latency.
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic    clk,
  input  logic    reset,
  e_mdu_if.slave  bus
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } md_op_e;

  md_op_e op;
  assign op = md_op_e'(bus.mdop);

  logic [31:0]   hi_q, lo_q, tmp_hi_q, tmp_lo_q;
  logic [31:0]   hi_d, lo_d, tmp_hi_d, tmp_lo_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          zdiv_q, zdiv_d;
  logic          busy_q;

  logic [63:0] prod_s, prod_u;
  logic        b_zero;
  logic [31:0] divisor_u, qu, ru;
  logic [31:0] abs_a, abs_b, divisor_s, uq, ur, sq, sr;

  // Result datapath: all four arithmetic results from the raw operands
  always_comb begin
    prod_s    = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    prod_u    = {32'd0, bus.a} * {32'd0, bus.b};
    b_zero    = (bus.b == '0);
    // divide-by-zero result is discarded; a dummy divisor keeps the datapath X-free
    divisor_u = b_zero ? 32'd1 : bus.b;
    qu        = bus.a / divisor_u;
    ru        = bus.a % divisor_u;
    // signed divide via magnitudes; 0x80000000 / -1 naturally yields
    // quotient 0x80000000, remainder 0 (magnitude wraps back to itself)
    abs_a     = bus.a[31] ? -bus.a : bus.a;
    abs_b     = bus.b[31] ? -bus.b : bus.b;
    divisor_s = b_zero ? 32'd1 : abs_b;
    uq        = abs_a / divisor_s;
    ur        = abs_a % divisor_s;
    sq        = (bus.a[31] ^ bus.b[31]) ? -uq : uq;
    sr        = bus.a[31] ? -ur : ur;
  end

  // Next-state: countdown/commit while running, accept new ops when idle
  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    tmp_hi_d = tmp_hi_q;
    tmp_lo_d = tmp_lo_q;
    cnt_d    = cnt_q;
    zdiv_d   = zdiv_q;
    if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == CW'(1)) begin
        if (!zdiv_q) begin
          hi_d = tmp_hi_q;
          lo_d = tmp_lo_q;
        end
        zdiv_d = 1'b0;
      end
    end else begin
      unique case (op)
        OP_MULT: begin
          tmp_hi_d = prod_s[63:32];
          tmp_lo_d = prod_s[31:0];
          cnt_d    = CW'(MULT_CYCLES);
          zdiv_d   = 1'b0;
        end
        OP_MULTU: begin
          tmp_hi_d = prod_u[63:32];
          tmp_lo_d = prod_u[31:0];
          cnt_d    = CW'(MULT_CYCLES);
          zdiv_d   = 1'b0;
        end
        OP_DIV: begin
          tmp_hi_d = sr;
          tmp_lo_d = sq;
          cnt_d    = CW'(DIV_CYCLES);
          zdiv_d   = b_zero;
        end
        OP_DIVU: begin
          tmp_hi_d = ru;
          tmp_lo_d = qu;
          cnt_d    = CW'(DIV_CYCLES);
          zdiv_d   = b_zero;
        end
        OP_MTHI: hi_d = bus.a;
        OP_MTLO: lo_d = bus.a;
        default: ;
      endcase
    end
  end

  // State registers, cleared asynchronously by active-low reset
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      tmp_hi_q <= '0;
      tmp_lo_q <= '0;
      cnt_q    <= '0;
      zdiv_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      tmp_hi_q <= tmp_hi_d;
      tmp_lo_q <= tmp_lo_d;
      cnt_q    <= cnt_d;
      zdiv_q   <= zdiv_d;
      busy_q   <= (cnt_d != '0);
    end
  end

  assign bus.start   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  assign bus.busy    = busy_q;
  assign bus.hi      = hi_q;
  assign bus.lo      = lo_q;
  assign bus.rd_data = bus.rd_sel ? hi_q : lo_q;

endmodule
